// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types and helpers for the adder_arbiter slice.
//   arb_state_e : response-slot FSM (IDLE = empty, HOLD = result held)
//   PERF_W      : width of each per-requester accept counter
//   id_width(n) : index width for n requesters, never below 1
package adder_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int PERF_W = 16;

  function automatic int id_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_claa.sv
// CLAA: carry-lookahead adder, {cout, sum} = a + b + cin.
//   a, b  : WIDTH-bit operands
//   cin   : carry-in
//   sum   : low WIDTH bits of the result
//   cout  : carry-out (bit WIDTH of the result)
module CLAA #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   carry;

  assign g = a & b;
  assign p = a ^ b;

  // Carries written as the generate/propagate recurrence; each carry is a
  // pure function of g, p and cin, which synthesis flattens into lookahead.
  always_comb begin
    carry    = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      carry[i+1] = g[i] | (p[i] & carry[i]);
    end
  end

  assign sum  = p ^ carry[WIDTH-1:0];
  assign cout = carry[WIDTH];

endmodule

// File: rtl/adder_arbiter_rr.sv
// rr_arbiter: combinational round-robin arbiter.
//   req : request vector
//   ptr : index of the last winner; search starts at ptr+1 (mod N)
//   gnt : one-hot grant (zero when no request)
//   idx : winner index
//   any : at least one request present
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int unsigned p;
  int unsigned d;
  int unsigned best;

  // Each requester gets a distance from ptr+1 going round the ring; the
  // smallest distance wins. Iterating over k keeps every req/gnt index static.
  always_comb begin
    p    = 32'(ptr);
    d    = 0;
    best = N;
    idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      d = (k + N - 1 - p) % N;
      if (req[k] && (d < best)) begin
        best = d;
        idx  = ID_W'(k);
      end
    end
    any = (best < N);
  end

  always_comb begin
    gnt = '0;
    for (int unsigned k = 0; k < N; k++) begin
      gnt[k] = any && (idx == ID_W'(k));
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one CLAA adder between N_REQ requesters.
//   clk_i, rst_ni        : clock (rising edge), async active-low reset
//   req_valid_i/ready_o  : per-requester operand handshake (ready one-hot/zero)
//   a_i, b_i, c_i        : packed operands, requester k at [k*WORD_WIDTH +: WORD_WIDTH]
//   rsp_valid_o/ready_i  : single result channel with backpressure
//   rsp_id_o             : index of the requester that produced the result
//   rsp_sum_o, rsp_c_o   : registered a + b + c and its carry-out
// Optional: define ADDER_ARB_PERF_EN to add perf_cnt_o, one saturating
// 16-bit accept counter per requester.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int WORD_WIDTH = 16,
  localparam int ID_W       = id_width(N_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic [N_REQ*WORD_WIDTH-1:0] a_i,
  input  logic [N_REQ*WORD_WIDTH-1:0] b_i,
  input  logic [N_REQ-1:0]            c_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [ID_W-1:0]             rsp_id_o,
  output logic [WORD_WIDTH-1:0]       rsp_sum_o,
  output logic                        rsp_c_o
`ifdef ADDER_ARB_PERF_EN
  ,
  output logic [N_REQ*PERF_W-1:0]     perf_cnt_o
`endif
);

  arb_state_e            state_q;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       win;
  logic [N_REQ-1:0]      gnt;
  logic                  any;
  logic                  free;
  logic                  accept;
  logic [WORD_WIDTH-1:0] a_w;
  logic [WORD_WIDTH-1:0] b_w;
  logic                  c_w;
  logic [WORD_WIDTH-1:0] sum_w;
  logic                  cout_w;

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req (req_valid_i),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  // The slot is free when empty or when the held result drains this edge.
  assign free        = (state_q == IDLE) | rsp_ready_i;
  assign req_ready_o = free ? gnt : '0;
  assign accept      = any & free;
  assign rsp_valid_o = (state_q == HOLD);

  always_comb begin
    a_w = '0;
    b_w = '0;
    c_w = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win == ID_W'(k)) begin
        a_w = a_i[k*WORD_WIDTH +: WORD_WIDTH];
        b_w = b_i[k*WORD_WIDTH +: WORD_WIDTH];
        c_w = c_i[k];
      end
    end
  end

  CLAA #(
    .WIDTH (WORD_WIDTH)
  ) u_claa (
    .a    (a_w),
    .b    (b_w),
    .cin  (c_w),
    .sum  (sum_w),
    .cout (cout_w)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rsp_id_o  <= '0;
      rsp_sum_o <= '0;
      rsp_c_o   <= 1'b0;
    end else if (accept) begin
      state_q   <= HOLD;
      rsp_id_o  <= win;
      rsp_sum_o <= sum_w;
      rsp_c_o   <= cout_w;
    end else if (rsp_ready_i) begin
      state_q   <= IDLE;
    end
  end

  generate
    if (N_REQ > 1) begin : g_ptr
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ptr_q <= ID_W'(N_REQ - 1);
        end else if (accept) begin
          ptr_q <= win;
        end
      end
    end else begin : g_ptr_const
      assign ptr_q = '0;
    end
  endgenerate

`ifdef ADDER_ARB_PERF_EN
  logic [PERF_W-1:0] perf_cnt_q [N_REQ];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        perf_cnt_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (req_valid_i[k] && req_ready_o[k] && (perf_cnt_q[k] != '1)) begin
          perf_cnt_q[k] <= perf_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    perf_cnt_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      perf_cnt_o[k*PERF_W +: PERF_W] = perf_cnt_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed self-checking bench for adder_arbiter
// (N_REQ = 4, WORD_WIDTH = 16). Perf-counter checks are built only when
// ADDER_ARB_PERF_EN is defined.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  valid;
  logic [3:0]  ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  c;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_sum;
  logic        rsp_c;
`ifdef ADDER_ARB_PERF_EN
  logic [63:0] perf;
`endif

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  adder_arbiter #(
    .N_REQ      (4),
    .WORD_WIDTH (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (valid),
    .req_ready_o (ready),
    .a_i         (a),
    .b_i         (b),
    .c_i         (c),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_sum_o   (rsp_sum),
    .rsp_c_o     (rsp_c)
`ifdef ADDER_ARB_PERF_EN
    ,
    .perf_cnt_o  (perf)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci);
    return {1'b0, x} + {1'b0, y} + {16'b0, ci};
  endfunction

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [16:0] s);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'(1));
    chk({tag, "_id"},    64'(rsp_id),    64'(id));
    chk({tag, "_sum"},   64'(rsp_sum),   64'(s[15:0]));
    chk({tag, "_c"},     64'(rsp_c),     64'(s[16]));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] exp_s [4];
    int unsigned g;

    valid     = '0;
    a         = '0;
    b         = '0;
    c         = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_valid", 64'(rsp_valid), 64'(0));
    chk("rst_id",    64'(rsp_id),    64'(0));
    chk("rst_sum",   64'(rsp_sum),   64'(0));
    chk("rst_c",     64'(rsp_c),     64'(0));
    rst_n = 1'b1;

    // Single request from requester 0: 3 + 4 + 1 = 8
    valid     = 4'b0001;
    a[15:0]   = 16'h0003;
    b[15:0]   = 16'h0004;
    c[0]      = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("t1_ready", 64'(ready), 64'(4'b0001));
    cyc();
    chk_rsp("t1", 2'd0, 17'h00008);

    // No requests: result drains, slot returns to empty
    valid = '0;
    #1;
    chk("idle_ready", 64'(ready), 64'(0));
    cyc();
    chk("drain_valid", 64'(rsp_valid), 64'(0));

    // Overflow on requester 3: FFFF + 1 + 0 -> sum 0, carry 1
    valid     = 4'b1000;
    a[63:48]  = 16'hFFFF;
    b[63:48]  = 16'h0001;
    c[3]      = 1'b0;
    #1;
    chk("ovf_ready", 64'(ready), 64'(4'b1000));
    cyc();
    chk_rsp("ovf", 2'd3, 17'h10000);

    // Round robin with all four valid: grants 0,1,2,3,0
    for (int k = 0; k < 4; k++) begin
      a[k*16 +: 16] = 16'h1000 * 16'(k) + 16'h00F0;
      b[k*16 +: 16] = 16'h0F0F + 16'(k);
      c[k]          = (k % 2) == 1;
      exp_s[k]      = ref_add(a[k*16 +: 16], b[k*16 +: 16], c[k]);
    end
    a[63:48]  = 16'hF0F0;
    exp_s[3]  = ref_add(a[63:48], b[63:48], c[3]);
    valid     = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      g = i % 4;
      #1;
      chk("rr_ready", 64'(ready), 64'(1) << g);
      cyc();
      chk_rsp("rr", 2'(g), exp_s[g]);
    end

    // Backpressure: held result from requester 0, requesters 1 and 2 waiting
    rsp_ready = 1'b0;
    valid     = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 64'(ready), 64'(0));
      cyc();
      chk_rsp("bp_hold", 2'd0, exp_s[0]);
    end

    // Release: drain and accept requester 1 on the same edge
    rsp_ready = 1'b1;
    #1;
    chk("rel_ready", 64'(ready), 64'(4'b0010));
    cyc();
    chk_rsp("rel", 2'd1, exp_s[1]);

    // Asynchronous reset while holding a result
    valid     = '0;
    rsp_ready = 1'b0;
    #2;
    chk("pre_rst_valid", 64'(rsp_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(rsp_valid), 64'(0));
    chk("arst_sum",   64'(rsp_sum),   64'(0));
    chk("arst_id",    64'(rsp_id),    64'(0));
    cyc();
    rst_n     = 1'b1;
    valid     = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready", 64'(ready), 64'(4'b0001));
    cyc();
    chk_rsp("post_rst", 2'd0, exp_s[0]);

`ifdef ADDER_ARB_PERF_EN
    // Requester 3 alone, accepted every cycle until the counter saturates
    rst_n = 1'b0;
    #1;
    rst_n     = 1'b1;
    valid     = 4'b1000;
    rsp_ready = 1'b1;
    chk("perf_rst", perf, 64'(0));
    repeat (100) @(posedge clk);
    #1;
    chk("perf_100", 64'(perf[63:48]), 64'(100));
    repeat (69900) @(posedge clk);
    #1;
    valid = '0;
    chk("perf_sat",    64'(perf[63:48]), 64'(16'hFFFF));
    chk("perf_others", 64'(perf[47:0]),  64'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
